// File: rtl/unit_stream_rx.sv
`timescale 1ns/1ps
// unit_stream_rx
// Receive side of a 2-bit symbol stream. The block hunts for SYNC_WORD at any
// symbol alignment, then deserialises FRAME_WORDS payload words of WIDTH bits
// (MSB symbol first). After each frame it expects another SYNC_WORD. If that
// trailer is missing, lock is dropped and hunting restarts from the bits
// already in the shift register, so no symbols are lost.
//
// Optional feature: define UNIT_STREAM_RX_CHECK_EN to compare each payload
// word against an incrementing reference sequence. That reference restarts at
// 0 on every fresh lock and carries on across frames while lock is held.
// Without the macro, err and err_count are constant 0.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   ce         in   symbol valid; din is sampled only when ce=1
//   din[1:0]   in   symbol, din[1] is the more significant bit
//   word       out  last payload word received (held between updates)
//   word_valid out  one-clock pulse when word updates
//   locked     out  high while frame-synchronised
//   err        out  one-clock pulse with word_valid on a payload mismatch
//   err_count  out  saturating (255) mismatch count
module unit_stream_rx #(
    parameter int                WIDTH       = 18,
    parameter logic [WIDTH-1:0]  SYNC_WORD   = 18'h3A5C3,
    parameter int                FRAME_WORDS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic [1:0]       din,
    output logic [WIDTH-1:0] word,
    output logic             word_valid,
    output logic             locked,
    output logic             err,
    output logic [7:0]       err_count
);

    localparam int SYMS  = WIDTH / 2;
    localparam int SYM_W = (SYMS > 1) ? $clog2(SYMS) : 1;
    // pay_cnt briefly reaches FRAME_WORDS on the way into CHECK
    localparam int PAY_W = $clog2(FRAME_WORDS + 1);

    localparam logic [SYM_W-1:0] SYM_ZERO = {SYM_W{1'b0}};
    localparam logic [SYM_W-1:0] SYM_ONE  = SYM_W'(1);
    localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(SYMS - 1);
    localparam logic [PAY_W-1:0] PAY_ZERO = {PAY_W{1'b0}};
    localparam logic [PAY_W-1:0] PAY_ONE  = PAY_W'(1);
    localparam logic [PAY_W-1:0] PAY_LAST = PAY_W'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [WIDTH-1:0]  sr_r;
    logic [WIDTH-1:0]  sr_nxt_s;
    logic [WIDTH-1:0]  sr_shift_s;
    logic [SYM_W-1:0]  sym_cnt_r;
    logic [SYM_W-1:0]  sym_cnt_nxt_s;
    logic [PAY_W-1:0]  pay_cnt_r;
    logic [PAY_W-1:0]  pay_cnt_nxt_s;
    logic [WIDTH-1:0]  word_r;
    logic [WIDTH-1:0]  word_nxt_s;
    logic              word_valid_r;
    logic              word_valid_nxt_s;
    logic              locked_r;
    logic              locked_nxt_s;
    logic              sync_hit_s;
    logic              sym_last_s;

    // Comparisons use the shift register as it will look after this symbol
    assign sr_shift_s = {sr_r[WIDTH-3:0], din};
    assign sync_hit_s = (sr_shift_s == SYNC_WORD);
    assign sym_last_s = (sym_cnt_r == SYM_LAST);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_HUNT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_HUNT: begin
                if (ce && sync_hit_s) begin
                    state_nxt_s = ST_PAYLOAD;
                end else begin
                    state_nxt_s = ST_HUNT;
                end
            end
            ST_PAYLOAD: begin
                if (ce && sym_last_s && (pay_cnt_r == PAY_LAST)) begin
                    state_nxt_s = ST_CHECK;
                end else begin
                    state_nxt_s = ST_PAYLOAD;
                end
            end
            ST_CHECK: begin
                if (ce && sym_last_s) begin
                    state_nxt_s = sync_hit_s ? ST_PAYLOAD : ST_HUNT;
                end else begin
                    state_nxt_s = ST_CHECK;
                end
            end
            default: begin
                state_nxt_s = ST_HUNT;
            end
        endcase
    end

    // Datapath and output decode: shift register, counters, word capture
    always_comb begin
        sr_nxt_s         = sr_r;
        sym_cnt_nxt_s    = sym_cnt_r;
        pay_cnt_nxt_s    = pay_cnt_r;
        word_nxt_s       = word_r;
        word_valid_nxt_s = 1'b0;
        locked_nxt_s     = (state_nxt_s != ST_HUNT);
        if (ce) begin
            sr_nxt_s = sr_shift_s;
            case (state_r)
                ST_HUNT: begin
                    // counters sit at zero while hunting, ready for a lock
                    sym_cnt_nxt_s = SYM_ZERO;
                    pay_cnt_nxt_s = PAY_ZERO;
                end
                ST_PAYLOAD: begin
                    if (sym_last_s) begin
                        sym_cnt_nxt_s    = SYM_ZERO;
                        pay_cnt_nxt_s    = pay_cnt_r + PAY_ONE;
                        word_nxt_s       = sr_shift_s;
                        word_valid_nxt_s = 1'b1;
                    end else begin
                        sym_cnt_nxt_s = sym_cnt_r + SYM_ONE;
                    end
                end
                ST_CHECK: begin
                    if (sym_last_s) begin
                        sym_cnt_nxt_s = SYM_ZERO;
                        pay_cnt_nxt_s = PAY_ZERO;
                    end else begin
                        sym_cnt_nxt_s = sym_cnt_r + SYM_ONE;
                    end
                end
                default: begin
                    sym_cnt_nxt_s = SYM_ZERO;
                    pay_cnt_nxt_s = PAY_ZERO;
                end
            endcase
        end else begin
            sr_nxt_s = sr_r;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_r         <= {WIDTH{1'b0}};
            sym_cnt_r    <= SYM_ZERO;
            pay_cnt_r    <= PAY_ZERO;
            word_r       <= {WIDTH{1'b0}};
            word_valid_r <= 1'b0;
            locked_r     <= 1'b0;
        end else begin
            sr_r         <= sr_nxt_s;
            sym_cnt_r    <= sym_cnt_nxt_s;
            pay_cnt_r    <= pay_cnt_nxt_s;
            word_r       <= word_nxt_s;
            word_valid_r <= word_valid_nxt_s;
            locked_r     <= locked_nxt_s;
        end
    end

    assign word       = word_r;
    assign word_valid = word_valid_r;
    assign locked     = locked_r;

`ifdef UNIT_STREAM_RX_CHECK_EN
    localparam logic [WIDTH-1:0] EXP_ONE = WIDTH'(1);

    logic [WIDTH-1:0] expected_r;
    logic [WIDTH-1:0] expected_nxt_s;
    logic             err_r;
    logic             err_nxt_s;
    logic [7:0]       err_count_r;
    logic [7:0]       err_count_nxt_s;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : (v + 8'd1);
    endfunction

    // Reference sequence and mismatch detection for payload words
    always_comb begin
        expected_nxt_s  = expected_r;
        err_nxt_s       = 1'b0;
        err_count_nxt_s = err_count_r;
        if (ce && (state_r == ST_HUNT) && sync_hit_s) begin
            // fresh lock restarts the sequence; a CHECK->PAYLOAD pass does not
            expected_nxt_s = {WIDTH{1'b0}};
        end else if (word_valid_nxt_s) begin
            expected_nxt_s = expected_r + EXP_ONE;
            if (sr_shift_s != expected_r) begin
                err_nxt_s       = 1'b1;
                err_count_nxt_s = sat_inc8(err_count_r);
            end else begin
                err_nxt_s       = 1'b0;
                err_count_nxt_s = err_count_r;
            end
        end else begin
            expected_nxt_s = expected_r;
        end
    end

    // Reference and error registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            expected_r  <= {WIDTH{1'b0}};
            err_r       <= 1'b0;
            err_count_r <= 8'd0;
        end else begin
            expected_r  <= expected_nxt_s;
            err_r       <= err_nxt_s;
            err_count_r <= err_count_nxt_s;
        end
    end

    assign err       = err_r;
    assign err_count = err_count_r;
`else
    assign err       = 1'b0;
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_unit_stream_rx.sv
`timescale 1ns/1ps
// Scoreboard bench for unit_stream_rx. Each run builds a symbol list. A
// frame-level parser over that list pushes the expected payload words into a
// queue and records the expected locked / err_count after every symbol. A
// negedge monitor pops the queue on every word_valid and checks the other
// outputs against the recorded values.
module tb_unit_stream_rx;

    localparam int          FW   = 8;
    localparam logic [17:0] SYNC = 18'h3A5C3;
`ifdef UNIT_STREAM_RX_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        ce    = 1'b0;
    logic [1:0]  din   = 2'b00;
    logic [17:0] word;
    logic        word_valid;
    logic        locked;
    logic        err;
    logic [7:0]  err_count;

    unit_stream_rx dut (
        .clk        (clk),
        .reset      (reset),
        .ce         (ce),
        .din        (din),
        .word       (word),
        .word_valid (word_valid),
        .locked     (locked),
        .err        (err),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [17:0] w;
        logic        e;
    } ev_t;

    ev_t        q[$];
    logic [1:0] syms[$];
    bit         lock_after[4096];
    int         errc_after[4096];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         nsamp    = 0;
    bit         mon_en   = 1'b0;
    int         gap_min  = 0;
    int         gap_max  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // count symbols the DUT has sampled in the current run
    always @(posedge clk) begin
        if (!reset) nsamp <= 0;
        else if (ce) nsamp <= nsamp + 1;
    end

    // monitor: pop and compare on word_valid, track locked and err_count
    always @(negedge clk) begin
        int  last;
        ev_t ev;
        if (mon_en) begin
            last = nsamp - 1;
            if (word_valid) begin
                if (q.size() == 0 || q[0].idx != last) begin
                    chk("unexpected_word_valid", {31'd0, word_valid}, 32'd0);
                end else begin
                    ev = q.pop_front();
                    chk("word", {14'd0, word}, {14'd0, ev.w});
                    chk("err", {31'd0, err}, {31'd0, ev.e});
                end
            end else begin
                if (q.size() > 0 && q[0].idx == last) begin
                    ev = q.pop_front();
                    chk("missing_word_valid", {31'd0, word_valid}, 32'd1);
                end
                if (err) chk("err_without_word", {31'd0, err}, 32'd0);
            end
            chk("locked", {31'd0, locked}, (last < 0) ? 32'd0 : {31'd0, lock_after[last]});
            chk("err_count", {24'd0, err_count}, (last < 0) ? 32'd0 : errc_after[last]);
        end
    end

    // Frame parser: slide one symbol at a time until the sync word appears,
    // then consume FW nine-symbol words plus a nine-symbol trailer per frame.
    task automatic run_model();
        int          i;
        bit          in_frame;
        bit          e;
        logic [17:0] win;
        logic [17:0] expv;
        int          errc;
        ev_t         ev;
        i = 0; win = 18'd0; expv = 18'd0; errc = 0;
        while (i < syms.size()) begin
            win = (win << 2) | 18'(syms[i]);
            lock_after[i] = (win == SYNC);
            errc_after[i] = errc;
            i++;
            if (win == SYNC) begin
                expv = 18'd0;
                in_frame = 1'b1;
                while (in_frame) begin
                    for (int wn = 0; wn <= FW && in_frame; wn++) begin
                        for (int k = 0; k < 9 && in_frame; k++) begin
                            if (i >= syms.size()) begin
                                in_frame = 1'b0;
                            end else begin
                                win = (win << 2) | 18'(syms[i]);
                                lock_after[i] = 1'b1;
                                if (k == 8 && wn < FW) begin
                                    e = CHK && (win != expv);
                                    if (e && errc < 255) errc++;
                                    ev.idx = i; ev.w = win; ev.e = e;
                                    q.push_back(ev);
                                    expv = expv + 18'd1;
                                end
                                if (k == 8 && wn == FW && win != SYNC) begin
                                    lock_after[i] = 1'b0;
                                    in_frame = 1'b0;
                                end
                                errc_after[i] = errc;
                                i++;
                            end
                        end
                    end
                end
            end
        end
    endtask

    task automatic push_word(input logic [17:0] w);
        logic [17:0] t;
        for (int k = 8; k >= 0; k--) begin
            t = w >> (2 * k);
            syms.push_back(t[1:0]);
        end
    endtask

    task automatic push_junk(input int n, input bit rnd);
        for (int k = 0; k < n; k++) syms.push_back(rnd ? 2'($urandom) : 2'b01);
    endtask

    task automatic push_frame(input int base);
        for (int k = 0; k < FW; k++) push_word(18'(base + k));
    endtask

    task automatic check_reset_outputs();
        chk("rst_word", {14'd0, word}, 32'd0);
        chk("rst_word_valid", {31'd0, word_valid}, 32'd0);
        chk("rst_locked", {31'd0, locked}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_err_count", {24'd0, err_count}, 32'd0);
    endtask

    task automatic begin_run(input int gmin, input int gmax);
        mon_en = 1'b0; reset = 1'b0; ce = 1'b0; din = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        q.delete(); syms.delete();
        gap_min = gmin; gap_max = gmax;
        reset = 1'b1;
    endtask

    task automatic play();
        run_model();
        mon_en = 1'b1;
        foreach (syms[i]) begin
            ce = 1'b1; din = syms[i];
            @(posedge clk); #1;
            ce = 1'b0; din = 2'($urandom);
            repeat ($urandom_range(gap_max, gap_min)) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic end_run();
        repeat (3) @(negedge clk);
        #1;
        chk("scoreboard_empty", q.size(), 32'd0);
        mon_en = 1'b0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1: clean stream
        begin_run(0, 0);
        push_word(SYNC); push_frame(0); push_word(SYNC);
        play(); end_run();

        // 2: two idle clocks between every symbol
        begin_run(2, 2);
        push_word(SYNC); push_frame(0); push_word(SYNC);
        play(); end_run();

        // 3: junk before the sync
        begin_run(0, 0);
        push_junk(5, 1'b0); push_word(SYNC); push_frame(0); push_word(SYNC);
        play(); end_run();

        // 4: missing trailer, then relock
        begin_run(0, 1);
        push_word(SYNC); push_frame(0); push_word(18'h00000);
        push_word(SYNC); push_frame(0); push_word(SYNC);
        play(); end_run();

        // 5: reset in word 3, symbol 4
        begin_run(0, 0);
        push_word(SYNC); push_frame(0);
        for (int k = 0; k < 5 + 4 * 9; k++) void'(syms.pop_back());
        play();
        repeat (2) @(negedge clk);
        #1;
        chk("scoreboard_empty", q.size(), 32'd0);
        @(posedge clk); #2;
        mon_en = 1'b0; reset = 1'b0;
        #1;
        check_reset_outputs();
        begin_run(0, 0);
        for (int k = 4; k < 9; k++) syms.push_back(2'b00);
        for (int k = 4; k < FW; k++) push_word(18'(k));
        push_word(SYNC); push_frame(0); push_word(SYNC);
        play(); end_run();

        // 6: one wrong payload word, continuation, unlock, junk
        begin_run(0, 0);
        push_word(SYNC);
        push_word(18'd0); push_word(18'd1); push_word(18'd2); push_word(18'd5);
        push_word(18'd4); push_word(18'd5); push_word(18'd6); push_word(18'd7);
        push_word(SYNC); push_frame(8); push_word(18'h00000);
        push_junk(20, 1'b0);
        play(); end_run();

        // 7: randomised frames, gaps, corrupted trailers and payload
        for (int r = 0; r < 4; r++) begin
            int cnt;
            begin_run(0, 3);
            push_junk($urandom_range(6, 0), 1'b1);
            push_word(SYNC);
            cnt = 0;
            for (int f = 0; f < 3; f++) begin
                for (int k = 0; k < FW; k++) begin
                    push_word(($urandom_range(3, 0) == 0) ? 18'($urandom) : 18'(cnt));
                    cnt++;
                end
                if ($urandom_range(4, 0) == 0) begin
                    push_word(SYNC ^ 18'(1 << $urandom_range(17, 0)));
                    push_junk($urandom_range(4, 0), 1'b1);
                    push_word(SYNC);
                    cnt = 0;
                end else begin
                    push_word(SYNC);
                end
            end
            play(); end_run();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/unit_stream_rx.md
Name: unit_stream_rx

Overview:
- Receive-side counterpart of the 2-bit `dout` symbol stream that the unit under test produces under `ce` in the MyHDL/Yosys co-simulation benches.
- Hunts for a sync word and locks onto frame boundaries.
- Deserializes 2-bit symbols into WIDTH-bit payload words and drops lock when a frame's trailing sync word is missing.
- Sits in the bench or downstream fabric, directly fed by the unit's `dout`.

Parameters:
- WIDTH, 18, word width in bits; must be even; WIDTH/2 symbols per word.
- SYNC_WORD, 18'h3A5C3, frame sync pattern (WIDTH bits).
- FRAME_WORDS, 8, payload words between consecutive sync words; must be >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- ce  input  1  symbol-valid / clock enable; `din` is sampled only when ce=1.
- din  input  2  symbol; `din[1]` is the more significant bit; words are sent MSB symbol first.
- word  output  WIDTH  last received payload word; holds its value between updates.
- word_valid  output  1  one-clk pulse when `word` updates.
- locked  output  1  high while frame-synchronised.
- err  output  1  one-clk pulse on payload mismatch (optional feature).
- err_count  output  8  saturating mismatch counter (optional feature).

Behaviour:
- Reset (reset=0, async, regardless of clk):
  - State = HUNT.
  - Shift register, symbol count, payload count and expected value all = 0.
  - Outputs: word=0, word_valid=0, locked=0, err=0, err_count=0.
- Shift rule: on every clk with ce=1, `sr <= {sr[WIDTH-3:0], din}`.
- ce=0: no state, counter or shift-register change. word_valid and err are 0 on any cycle without a qualifying completion; they are pulses, never held.
- HUNT:
  - Compare the updated `sr` (including the current din) to SYNC_WORD.
  - On match, next state = PAYLOAD, sym_cnt=0, pay_cnt=0, locked=1.
  - locked is visible the clk after the last sync symbol is sampled.
  - Matching is at symbol granularity; any alignment works.
- PAYLOAD:
  - sym_cnt counts 0..WIDTH/2-1.
  - On the clk that samples the last symbol: word <= updated sr, word_valid=1 (latency one clk from last symbol sample), sym_cnt wraps to 0, pay_cnt increments.
  - When the completed word is number FRAME_WORDS-1 (pay_cnt = FRAME_WORDS-1), next state = CHECK.
- CHECK:
  - Assemble WIDTH/2 symbols; no word_valid is issued for the sync word.
  - On completion, if the updated sr == SYNC_WORD: next state = PAYLOAD, pay_cnt=0, locked stays 1.
  - Else: next state = HUNT, locked=0 on the next clk. `sr` is retained, so HUNT resumes immediately from the current contents with no symbol loss.
- Junk before the first sync: ignored, produces no output.
- Reset mid-word or mid-frame: all partial state discarded; relock requires a full sync word.
- word_valid and locked change only on clk edges, except for the asynchronous reset.

Optional Feature:
- Macro: UNIT_STREAM_RX_CHECK_EN.
- Defined:
  - Internal `expected` (WIDTH bits) is cleared when entering PAYLOAD from HUNT. It is not cleared on a CHECK->PAYLOAD transition, so the sequence continues across frames.
  - Each payload word is compared to `expected`. On mismatch: err=1 for one clk, coincident with word_valid, and err_count increments, saturating at 255.
  - `expected` increments modulo 2^WIDTH after every payload word, regardless of match.
  - err_count is cleared only by reset.
- Undefined: err and err_count are tied to 0, with ports still present; no comparator or counter logic is synthesised.

Test Plan:
1. Reset, then SYNC_WORD, payload 0..7, SYNC_WORD, all with ce=1 -> locked=1 the clk after the 9th sync symbol; 8 word_valid pulses spaced 9 clks apart, word=0..7; locked still 1 after the second sync.
2. Same stream with ce=0 for 2 clks between every symbol -> identical word values and pulse count; no pulses during gaps; locked timing scales accordingly.
3. 5 junk symbols (din=2'b01) then stream from test 1 -> lock acquired exactly after the sync; no word_valid before lock.
4. Frame with the trailing sync replaced by 18'h00000 -> no word_valid for it; locked drops to 0 one clk after its last symbol. A following valid SYNC_WORD relocks.
5. Assert reset for 1 clk mid-payload (word 3, symbol 4) -> all outputs 0 immediately; after release, relock only after a fresh SYNC_WORD; no stale word emitted.
6. With UNIT_STREAM_RX_CHECK_EN: SYNC, payload 0,1,2,5,4,5,6,7 -> single err pulse with word=5 (4th word), err_count=1. Unlocked stream -> err_count unchanged. Without the macro -> err and err_count stay 0.
